// File: rtl/scaler_linear_v_mch.sv
// Vertical linear-interpolation scaler, multi-channel: 3-line ring buffer, fractional
// line stepping, 5-stage read/select/mult/sum/out pipeline with frame abort and overrun flag.

module scaler_linear_v_lane #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LINE_STEP   = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2:0][PIXEL_WIDTH-1:0]   ent_i,
    input  logic [1:0]                    sel_a_i,
    input  logic [1:0]                    sel_b_i,
    input  logic [$clog2(LINE_STEP):0]    dy_i,
    output logic [PIXEL_WIDTH-1:0]        pix_o
);
    localparam int LB  = $clog2(LINE_STEP);
    localparam int PRW = PIXEL_WIDTH + LB + 1;
    localparam int SMW = PRW + 1;

    logic [PIXEL_WIDTH-1:0] a_d, a_q, b_d, b_q, pix_d, pix_q;
    logic [PRW-1:0]         pa_d, pa_q, pb_d, pb_q;
    logic [SMW-1:0]         sum_d, sum_q, shr;
    logic [LB:0]            wa;

    always_comb begin
        a_d   = (sel_a_i == 2'd2) ? ent_i[2] : (sel_a_i == 2'd1) ? ent_i[1] : ent_i[0];
        b_d   = (sel_b_i == 2'd2) ? ent_i[2] : (sel_b_i == 2'd1) ? ent_i[1] : ent_i[0];
        wa    = (LB+1)'(LINE_STEP) - dy_i;
        pa_d  = PRW'(a_q) * PRW'(wa);
        pb_d  = PRW'(b_q) * PRW'(dy_i);
        sum_d = SMW'(pa_q) + SMW'(pb_q) + SMW'(LINE_STEP / 2);
        shr   = sum_q >> LB;
        pix_d = (shr > SMW'((1 << PIXEL_WIDTH) - 1)) ? '1 : shr[PIXEL_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0; b_q <= '0; pa_q <= '0; pb_q <= '0; sum_q <= '0; pix_q <= '0;
        end else begin
            a_q <= a_d; b_q <= b_d; pa_q <= pa_d; pb_q <= pb_d; sum_q <= sum_d; pix_q <= pix_d;
        end
    end

    assign pix_o = pix_q;
endmodule

module scaler_linear_v_mch #(
    parameter int LINE_IN_SIZE_MAX = 1024,
    parameter int LINE_STEP        = 4096,
    parameter int CHANNELS         = 3,
    parameter int PIXEL_WIDTH      = 8,
    parameter int SPARSE_OUT       = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [15:0]                     scale_step,
    input  logic [15:0]                     line_in_size,
    input  logic                            bypass,
    input  logic [CHANNELS*PIXEL_WIDTH-1:0] di_i,
    input  logic                            de_i,
    input  logic                            hs_i,
    input  logic                            vs_i,
    output logic [CHANNELS*PIXEL_WIDTH-1:0] do_o,
    output logic                            de_o,
    output logic                            hs_o,
    output logic                            vs_o,
    output logic                            err_overrun
);
    localparam int LB     = $clog2(LINE_STEP);
    localparam int AW     = $clog2(LINE_IN_SIZE_MAX);
    localparam int DW     = CHANNELS * PIXEL_WIDTH;
    localparam int STAGES = 5;

    typedef enum logic [1:0] {S_IDLE, S_PRM, S_GEN} state_t;

    state_t              state_q, state_d;
    logic [23:0]         cnt_o_q, cnt_o_d;
    logic [15:0]         lines_in_q, lines_in_d, wr_line_q, wr_line_d, wr_ptr_q, wr_ptr_d;
    logic [15:0]         rd_addr_q, rd_addr_d, size_q, size_d, step_q, step_d;
    logic [1:0]          wr_slot_q, wr_slot_d, slot_a_q, slot_a_d;
    logic                frm_act_q, frm_act_d, line_open_q, line_open_d;
    logic                sof_line_q, sof_line_d, err_q, err_d;
    logic [3:0]          sp_cnt_q, sp_cnt_d;
    logic [LB:0]         dy_q, dy_d;
    logic [STAGES:1]     vld_pipe_q, vld_pipe_d, hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;

    logic        sof, start, wr_en, wr_last, rd_stb;
    logic [15:0] wr_addr;
    logic [31:0] j_ext;
    logic [1:0]  slot_b;

    logic [DW-1:0]                               mem [3][LINE_IN_SIZE_MAX];
    logic [2:0][DW-1:0]                          rd_q;
    logic [CHANNELS-1:0][2:0][PIXEL_WIDTH-1:0]   lane_ent;
    logic [CHANNELS-1:0][PIXEL_WIDTH-1:0]        lane_out;

    // Anything before the first frame start is not part of a frame and is dropped.
    assign sof     = de_i & hs_i & vs_i;
    assign start   = de_i & hs_i & (vs_i | frm_act_q);
    assign wr_en   = de_i & (sof | frm_act_q);
    assign wr_addr = start ? 16'd0 : wr_ptr_q;
    assign wr_last = wr_en & (wr_addr == line_in_size);
    assign j_ext   = 32'(cnt_o_q >> LB);
    assign slot_b  = (slot_a_q == 2'd2) ? 2'd0 : slot_a_q + 2'd1;

    always_comb begin
        frm_act_d   = frm_act_q | sof;
        wr_ptr_d    = wr_en ? wr_addr + 16'd1 : wr_ptr_q;
        wr_slot_d   = sof ? 2'd0 : start ? ((wr_slot_q == 2'd2) ? 2'd0 : wr_slot_q + 2'd1) : wr_slot_q;
        wr_line_d   = sof ? 16'd0 : start ? wr_line_q + 16'd1 : wr_line_q;
        line_open_d = wr_last ? 1'b0 : start ? 1'b1 : line_open_q;
        lines_in_d  = (sof ? 16'd0 : lines_in_q) + {15'd0, start & ~sof & line_open_q} + {15'd0, wr_last};
        err_d       = err_q;
        if (start && !sof && state_q != S_IDLE && 32'(wr_line_d) >= j_ext + 32'd3)
            err_d = 1'b1;
        if (sof)
            err_d = 1'b0;

        state_d    = state_q;
        cnt_o_d    = cnt_o_q;
        rd_addr_d  = rd_addr_q;
        size_d     = size_q;
        step_d     = step_q;
        slot_a_d   = slot_a_q;
        sof_line_d = sof_line_q;
        sp_cnt_d   = sp_cnt_q;
        dy_d       = dy_q;
        rd_stb     = 1'b0;
        case (state_q)
            S_IDLE: if (frm_act_q && 32'(lines_in_q) > j_ext + 32'd1) state_d = S_PRM;
            S_PRM: begin
                state_d    = S_GEN;
                slot_a_d   = 2'(j_ext % 32'd3);
                dy_d       = bypass ? '0 : {1'b0, cnt_o_q[LB-1:0]};
                step_d     = (bypass || scale_step == 16'd0) ? 16'(LINE_STEP) : scale_step;
                size_d     = line_in_size;
                sof_line_d = (cnt_o_q == 24'd0);
                rd_addr_d  = 16'd0;
                sp_cnt_d   = 4'd0;
            end
            S_GEN: begin
                if (sp_cnt_q == 4'd0) begin
                    rd_stb = 1'b1;
                    if (rd_addr_q == size_q) begin
                        cnt_o_d = cnt_o_q + 24'(step_q);
                        state_d = S_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + 16'd1;
                        sp_cnt_d  = 4'(SPARSE_OUT);
                    end
                end else begin
                    sp_cnt_d = sp_cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        vld_pipe_d = {vld_pipe_q[STAGES-1:1], rd_stb};
        hs_pipe_d  = {hs_pipe_q[STAGES-1:1], rd_stb & (rd_addr_q == 16'd0)};
        vs_pipe_d  = {vs_pipe_q[STAGES-1:1], rd_stb & (rd_addr_q == 16'd0) & sof_line_q};
        // A frame start wins over everything, including a line finishing this cycle.
        if (sof) begin
            state_d    = S_IDLE;
            cnt_o_d    = 24'd0;
            vld_pipe_d = '0;
            hs_pipe_d  = '0;
            vs_pipe_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;      cnt_o_q <= '0;      lines_in_q <= '0;
            wr_line_q <= '0;        wr_ptr_q <= '0;     rd_addr_q <= '0;
            size_q <= '0;           step_q <= '0;       wr_slot_q <= '0;
            slot_a_q <= '0;         frm_act_q <= 1'b0;  line_open_q <= 1'b0;
            sof_line_q <= 1'b0;     err_q <= 1'b0;      sp_cnt_q <= '0;
            dy_q <= '0;             vld_pipe_q <= '0;   hs_pipe_q <= '0;
            vs_pipe_q <= '0;
        end else begin
            state_q <= state_d;     cnt_o_q <= cnt_o_d; lines_in_q <= lines_in_d;
            wr_line_q <= wr_line_d; wr_ptr_q <= wr_ptr_d; rd_addr_q <= rd_addr_d;
            size_q <= size_d;       step_q <= step_d;   wr_slot_q <= wr_slot_d;
            slot_a_q <= slot_a_d;   frm_act_q <= frm_act_d; line_open_q <= line_open_d;
            sof_line_q <= sof_line_d; err_q <= err_d;   sp_cnt_q <= sp_cnt_d;
            dy_q <= dy_d;           vld_pipe_q <= vld_pipe_d; hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && 32'(wr_addr) < LINE_IN_SIZE_MAX)
            mem[wr_slot_d][wr_addr[AW-1:0]] <= di_i;
        if (rd_stb)
            for (int e = 0; e < 3; e++) rd_q[e] <= mem[e][rd_addr_q[AW-1:0]];
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++)
            for (int e = 0; e < 3; e++)
                lane_ent[c][e] = rd_q[e][c*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

    // slot/dy stay valid for the tail of a line: they are only re-latched in PRM,
    // which is at least two cycles after the last strobe.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        scaler_linear_v_lane #(.PIXEL_WIDTH(PIXEL_WIDTH), .LINE_STEP(LINE_STEP)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .ent_i   (lane_ent[c]),
            .sel_a_i (slot_a_q),
            .sel_b_i (slot_b),
            .dy_i    (dy_q),
            .pix_o   (lane_out[c])
        );
    end

    assign do_o        = lane_out;
    assign de_o        = vld_pipe_q[STAGES];
    assign hs_o        = hs_pipe_q[STAGES];
    assign vs_o        = vs_pipe_q[STAGES];
    assign err_overrun = err_q;
endmodule
